// File: rtl/piezo_capture_pkg.sv
// Shared types and sizing helpers for the piezo capture array.
// Pure declarations: no logic, no latency, no flow control.
package piezo_capture_pkg;

    typedef enum logic [1:0] {
        ST_ARMED   = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_READY   = 2'd2,
        ST_DRAINED = 2'd3
    } state_t;

    function automatic int frame_bits(input int n_ch, input int ts_w);
        return n_ch * ts_w;
    endfunction

    // Must hold the value frame_bits itself, hence the +1.
    function automatic int bit_cnt_width(input int n_ch, input int ts_w);
        return $clog2(n_ch * ts_w + 1);
    endfunction

endpackage

// File: rtl/piezo_capture_channel.sv
// One trigger channel: synchroniser, edge detect, timestamp register and valid flag.
// Edge visible SYNC_STAGES clk after the pin moves, stored one clk later; no backpressure.
module capture_channel
    import piezo_capture_pkg::*;
#(
    parameter int TS_W        = 32,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE        = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            trigger,
    input  logic            arm_clear,
    input  logic            capture_en,
    input  logic [TS_W-1:0] counter,
    input  logic            force_ones,
    output logic            trig_edge,
    output logic            valid,
    output logic [TS_W-1:0] ts
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   level;

    assign level     = sync_q[SYNC_STAGES-1];
    assign trig_edge = (EDGE == 0) ? (level & ~prev_q) : (~level & prev_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            valid  <= 1'b0;
            ts     <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], trigger};
            prev_q <= level;
            // Timestamps survive a clear so the last frame stays inspectable.
            if (arm_clear) begin
                valid <= 1'b0;
            end else if (capture_en && trig_edge && !valid) begin
                ts    <= counter;
                valid <= 1'b1;
            end else if (force_ones && !valid) begin
                ts <= '1;
            end
        end
    end

endmodule

// File: rtl/piezo_capture_array.sv
// Per-channel trigger delay capture with serial readout paced by a host data_clk.
// Frame appears the clk after the last capture; host shifts at will, no backpressure.
module piezo_capture_array
    import piezo_capture_pkg::*;
#(
    parameter int     N_CH        = 4,
    parameter int     TS_W        = 32,
    parameter int     SYNC_STAGES = 2,
    parameter int     EDGE        = 0,
    parameter longint TIMEOUT     = 0,
    parameter int     AUTO_REARM  = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] triggers,
    input  logic            rearm,
    input  logic            data_clk,
    output logic            data_out,
    output logic            data_ready,
    output logic            timed_out,
    output logic [N_CH-1:0] valid_mask,
    output logic            armed
);

    localparam int              FB     = frame_bits(N_CH, TS_W);
    localparam int              BC_W   = bit_cnt_width(N_CH, TS_W);
    localparam logic [TS_W-1:0] TS_MAX = '1;
    localparam logic [TS_W-1:0] TO_VAL = TS_W'(TIMEOUT);

    state_t                 state;
    logic [TS_W-1:0]        counter;
    logic [FB-1:0]          shreg;
    logic [FB-1:0]          frame_next;
    logic [BC_W-1:0]        bit_cnt;
    logic [N_CH-1:0]        edges;
    logic [N_CH-1:0]        valids;
    logic [N_CH-1:0]        hit;
    logic [N_CH-1:0]        valid_next;
    logic [TS_W-1:0]        ts [N_CH];
    logic                   capture_en;
    logic                   force_ones;
    logic                   all_valid;
    logic                   timeout_hit;
    logic                   arm_clear;
    logic [SYNC_STAGES-1:0] dclk_sync;
    logic                   dclk_prev;
    logic                   shift_en;

    assign capture_en  = ((state == ST_ARMED) || (state == ST_CAPTURE)) && !rearm;
    assign hit         = edges & ~valids & {N_CH{capture_en}};
    assign valid_next  = valids | hit;
    assign all_valid   = &valid_next;
    assign timeout_hit = (TIMEOUT != 0) && (state == ST_CAPTURE) && (counter == TO_VAL)
                         && !all_valid && !rearm;
    assign force_ones  = timeout_hit;
    assign arm_clear   = rearm || ((state == ST_DRAINED) && (AUTO_REARM != 0));

    assign valid_mask = valids;
    assign data_out   = shreg[FB-1];
    assign armed      = (state == ST_ARMED);
    assign shift_en   = dclk_sync[SYNC_STAGES-1] & ~dclk_prev;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        capture_channel #(
            .TS_W        (TS_W),
            .SYNC_STAGES (SYNC_STAGES),
            .EDGE        (EDGE)
        ) u_ch (
            .clk        (clk),
            .reset      (reset),
            .trigger    (triggers[g]),
            .arm_clear  (arm_clear),
            .capture_en (capture_en),
            .counter    (counter),
            .force_ones (force_ones),
            .trig_edge  (edges[g]),
            .valid      (valids[g]),
            .ts         (ts[g])
        );
    end

    // Channel registers update on the same edge that enters READY, so the
    // frame is assembled from their next values; ch0 lands in the MSBs.
    always_comb begin
        frame_next = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (hit[i])
                frame_next[(N_CH-1-i)*TS_W +: TS_W] = counter;
            else if (force_ones && !valids[i])
                frame_next[(N_CH-1-i)*TS_W +: TS_W] = TS_MAX;
            else
                frame_next[(N_CH-1-i)*TS_W +: TS_W] = ts[i];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dclk_sync <= '0;
            dclk_prev <= 1'b0;
        end else begin
            dclk_sync <= {dclk_sync[SYNC_STAGES-2:0], data_clk};
            dclk_prev <= dclk_sync[SYNC_STAGES-1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_ARMED;
            counter    <= '0;
            shreg      <= '0;
            bit_cnt    <= '0;
            data_ready <= 1'b0;
            timed_out  <= 1'b0;
        end else if (rearm) begin
            state      <= ST_ARMED;
            counter    <= '0;
            shreg      <= '0;
            bit_cnt    <= '0;
            data_ready <= 1'b0;
            timed_out  <= 1'b0;
        end else begin
            case (state)
                ST_ARMED: begin
                    if (|hit) begin
                        if (all_valid) begin
                            state      <= ST_READY;
                            shreg      <= frame_next;
                            data_ready <= 1'b1;
                        end else begin
                            // First CAPTURE cycle must read 1 so deltas are exact.
                            state   <= ST_CAPTURE;
                            counter <= TS_W'(1);
                        end
                    end
                end
                ST_CAPTURE: begin
                    if (counter != TS_MAX)
                        counter <= counter + TS_W'(1);
                    if (all_valid || timeout_hit) begin
                        state      <= ST_READY;
                        shreg      <= frame_next;
                        data_ready <= 1'b1;
                        timed_out  <= timeout_hit;
                    end
                end
                ST_READY: begin
                    if (shift_en) begin
                        shreg   <= shreg << 1;
                        bit_cnt <= bit_cnt + BC_W'(1);
                        if (bit_cnt == BC_W'(FB - 1)) begin
                            state      <= ST_DRAINED;
                            data_ready <= 1'b0;
                        end
                    end
                end
                ST_DRAINED: begin
                    if (AUTO_REARM != 0) begin
                        state     <= ST_ARMED;
                        counter   <= '0;
                        bit_cnt   <= '0;
                        timed_out <= 1'b0;
                    end
                end
                default: state <= ST_ARMED;
            endcase
        end
    end

endmodule

// File: tb/tb_piezo_capture_array.sv
// Bench: two instances (manual re-arm with timeout, auto re-arm without) share stimulus;
// sel picks which one the scoreboard observes.
module tb_piezo_capture_array;

    typedef struct packed {
        logic [63:0] frame;
        logic [3:0]  mask;
        logic        to;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] triggers;
    logic       rearm;
    logic       data_clk;
    logic       sel;

    logic       a_dout, a_ready, a_to, a_armed;
    logic [3:0] a_mask;
    logic       b_dout, b_ready, b_to, b_armed;
    logic [3:0] b_mask;

    logic       o_dout, o_ready, o_to, o_armed;
    logic [3:0] o_mask;

    int   total = 0;
    int   bad   = 0;
    exp_t exp_q[$];
    logic bit_q[$];

    always #5 clk = ~clk;

    piezo_capture_array #(
        .N_CH(4), .TS_W(16), .SYNC_STAGES(2), .EDGE(0), .TIMEOUT(1000), .AUTO_REARM(0)
    ) dut_a (
        .clk(clk), .reset(reset), .triggers(triggers), .rearm(rearm), .data_clk(data_clk),
        .data_out(a_dout), .data_ready(a_ready), .timed_out(a_to), .valid_mask(a_mask),
        .armed(a_armed)
    );

    piezo_capture_array #(
        .N_CH(4), .TS_W(16), .SYNC_STAGES(2), .EDGE(0), .TIMEOUT(0), .AUTO_REARM(1)
    ) dut_b (
        .clk(clk), .reset(reset), .triggers(triggers), .rearm(rearm), .data_clk(data_clk),
        .data_out(b_dout), .data_ready(b_ready), .timed_out(b_to), .valid_mask(b_mask),
        .armed(b_armed)
    );

    assign o_dout  = sel ? b_dout  : a_dout;
    assign o_ready = sel ? b_ready : a_ready;
    assign o_to    = sel ? b_to    : a_to;
    assign o_armed = sel ? b_armed : a_armed;
    assign o_mask  = sel ? b_mask  : a_mask;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h (t=%0t)", tag, got, want, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_rearm();
        rearm = 1'b1;
        tick(1);
        rearm = 1'b0;
    endtask

    task automatic push_exp(input logic [63:0] frame, input logic [3:0] mask, input logic to);
        exp_t e;
        e.frame = frame;
        e.mask  = mask;
        e.to    = to;
        exp_q.push_back(e);
        for (int i = 63; i >= 0; i--) bit_q.push_back(frame[i]);
    endtask

    task automatic wait_ready(input string tag, input int budget);
        int n = 0;
        while (!o_ready && n < budget) begin
            tick(1);
            n++;
        end
        chk(tag, 64'(o_ready), 64'd1);
    endtask

    task automatic check_event(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            chk({tag, "_queue"}, 64'd0, 64'd1);
            return;
        end
        e = exp_q.pop_front();
        chk({tag, "_mask"},  64'(o_mask),  64'(e.mask));
        chk({tag, "_tout"},  64'(o_to),    64'(e.to));
        chk({tag, "_armed"}, 64'(o_armed), 64'd0);
    endtask

    task automatic next_bit(input string tag);
        logic b;
        if (bit_q.size() == 0) begin
            chk({tag, "_bitq"}, 64'd0, 64'd1);
            return;
        end
        b = bit_q.pop_front();
        chk(tag, 64'(o_dout), 64'(b));
    endtask

    task automatic pulse(input int half);
        data_clk = 1'b1;
        tick(half);
        data_clk = 1'b0;
        tick(half);
    endtask

    // Reads a whole frame; the last shift is tracked cycle by cycle.
    task automatic read_frame(input string tag, input int half, input logic auto_mode);
        for (int i = 0; i < 63; i++) begin
            next_bit({tag, "_bit"});
            pulse(half);
        end
        next_bit({tag, "_bit63"});
        data_clk = 1'b1;
        tick(2);
        chk({tag, "_ready_pre"}, 64'(o_ready), 64'd1);
        tick(1);
        chk({tag, "_drained_ready"}, 64'(o_ready), 64'd0);
        chk({tag, "_drained_dout"},  64'(o_dout),  64'd0);
        chk({tag, "_drained_armed"}, 64'(o_armed), 64'd0);
        tick(1);
        chk({tag, "_post_armed"}, 64'(o_armed), 64'(auto_mode));
        data_clk = 1'b0;
        tick(half);
    endtask

    task automatic quiet();
        triggers = 4'h0;
        tick(5);
        do_rearm();
        tick(2);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        triggers = 4'h0;
        rearm    = 1'b0;
        data_clk = 1'b0;
        sel      = 1'b0;
        tick(3);
        chk("rst_dout",  64'(o_dout),  64'd0);
        chk("rst_ready", 64'(o_ready), 64'd0);
        chk("rst_tout",  64'(o_to),    64'd0);
        chk("rst_mask",  64'(o_mask),  64'd0);
        chk("rst_armed", 64'(o_armed), 64'd1);
        reset = 1'b0;
        tick(3);

        // Staggered rising edges; data_ready three clk after the final pin edge.
        quiet();
        push_exp({16'd37, 16'd300, 16'd0, 16'd50}, 4'hF, 1'b0);
        triggers[2] = 1'b1;
        tick(37);
        triggers[0] = 1'b1;
        tick(13);
        triggers[3] = 1'b1;
        tick(250);
        triggers[1] = 1'b1;
        tick(2);
        chk("stag_ready_early", 64'(o_ready), 64'd0);
        tick(1);
        chk("stag_ready_on", 64'(o_ready), 64'd1);
        check_event("stag");
        read_frame("stag", 4, 1'b0);

        // Timeout at counter 1000 with ch0/ch2 silent.
        quiet();
        push_exp({16'hFFFF, 16'd0, 16'hFFFF, 16'd20}, 4'b1010, 1'b1);
        triggers[1] = 1'b1;
        tick(20);
        triggers[3] = 1'b1;
        tick(1002 - 20);
        chk("tmo_ready_early", 64'(o_ready), 64'd0);
        tick(1);
        chk("tmo_ready_on", 64'(o_ready), 64'd1);
        check_event("tmo");
        read_frame("tmo", 4, 1'b0);

        // All channels in one cycle: READY straight from ARMED.
        quiet();
        push_exp(64'd0, 4'hF, 1'b0);
        triggers = 4'hF;
        tick(2);
        chk("all_ready_early", 64'(o_ready), 64'd0);
        tick(1);
        chk("all_ready_on", 64'(o_ready), 64'd1);
        check_event("all");
        read_frame("all", 5, 1'b0);
        pulse(5);
        chk("extra_dout",  64'(o_dout),  64'd0);
        chk("extra_ready", 64'(o_ready), 64'd0);
        chk("extra_armed", 64'(o_armed), 64'd0);

        // rearm coincides with the ch0 edge mid-capture; that edge must be lost.
        quiet();
        triggers[1] = 1'b1;
        tick(10);
        triggers[0] = 1'b1;
        tick(2);
        rearm = 1'b1;
        tick(1);
        rearm = 1'b0;
        chk("rearm_armed", 64'(o_armed), 64'd1);
        chk("rearm_mask",  64'(o_mask),  64'd0);
        chk("rearm_ready", 64'(o_ready), 64'd0);
        triggers = 4'h0;
        tick(5);
        chk("rearm_still_armed", 64'(o_armed), 64'd1);
        push_exp({16'd0, 16'd5, 16'd7, 16'd9}, 4'hF, 1'b0);
        triggers[0] = 1'b1;
        tick(5);
        triggers[1] = 1'b1;
        tick(2);
        triggers[2] = 1'b1;
        tick(2);
        triggers[3] = 1'b1;
        wait_ready("fresh_ready", 10);
        check_event("fresh");
        read_frame("fresh", 4, 1'b0);

        // Auto re-arm instance, slow host clock, patterned frame.
        sel = 1'b1;
        quiet();
        push_exp({16'd0, 16'd1, 16'd2, 16'hA5A5}, 4'hF, 1'b0);
        triggers[0] = 1'b1;
        tick(1);
        triggers[1] = 1'b1;
        tick(1);
        triggers[2] = 1'b1;
        tick(16'hA5A5 - 2);
        triggers[3] = 1'b1;
        wait_ready("pat_ready", 10);
        check_event("pat");
        read_frame("pat", 5, 1'b1);

        // Async reset in the middle of a readout.
        quiet();
        push_exp({16'd3, 16'd0, 16'd3, 16'd3}, 4'hF, 1'b0);
        triggers[1] = 1'b1;
        tick(3);
        triggers = 4'hF;
        wait_ready("mid_ready", 10);
        check_event("mid");
        for (int i = 0; i < 14; i++) begin
            next_bit("mid_bit");
            pulse(4);
        end
        next_bit("mid_bit14");
        #2;
        reset = 1'b1;
        #1;
        chk("arst_dout",  64'(o_dout),  64'd0);
        chk("arst_ready", 64'(o_ready), 64'd0);
        chk("arst_tout",  64'(o_to),    64'd0);
        chk("arst_mask",  64'(o_mask),  64'd0);
        tick(2);
        reset = 1'b0;
        bit_q.delete();
        tick(1);
        chk("arst_armed", 64'(o_armed), 64'd1);
        chk("left_exp", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
